// File: rtl/chunked_add_sequencer.sv
// chunked_add_sequencer
//
// Multi-cycle WIDTH-bit add/subtract built from one CHUNK-bit ripple-carry
// slice that is reused over N = WIDTH/CHUNK beats, with the carry held in a
// register between beats.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready operand handshake (a, b, cin, sub)
//   a, b                WIDTH-bit operands
//   cin                 carry-in, used only for addition
//   sub                 0: a + b + cin, 1: a - b (a + ~b + 1)
//   out_valid/out_ready result handshake (sum, cout, ovf)
//   sum                 WIDTH-bit result, meaningful only while out_valid=1
//   cout                carry out of the top bit (1 = no borrow when sub=1)
//   ovf                 two's-complement signed overflow
module chunked_add_sequencer #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  sum_r;
    logic              cout_r;
    logic              ovf_r;
    logic [31:0]       base;
    logic [CHUNK-1:0]  chunk_a;
    logic [CHUNK-1:0]  chunk_b;
    logic [CHUNK:0]    slice;

    // State register: the only place the FSM state is stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one beat per RUN cycle, leave RUN on the last chunk,
    // and hold DONE until the consumer takes the result.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid)     next_state = RUN;
            RUN:  if (idx == LAST)  next_state = DONE;
            DONE: if (out_ready)    next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // Output decode: handshake outputs come from the registered state only;
    // in_ready is also held low while reset is asserted.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    // The shared adder slice: picks the current chunk of both operands and
    // adds it with the carry left over from the previous beat.
    always_comb begin
        base    = 32'(idx) * 32'(CHUNK);
        chunk_a = opa[base +: CHUNK];
        chunk_b = opb[base +: CHUNK];
        slice   = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};
    end

    // Datapath: operands are captured once at acceptance (b pre-inverted for
    // subtraction, so the slice only ever adds), then one chunk of the result
    // is written per RUN beat. The final beat also produces cout and ovf,
    // where ovf compares the sign bits of opa, the post-inversion opb and the
    // top result bit coming out of the slice on that same beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_r[base +: CHUNK] <= slice[CHUNK-1:0];
                    carry                <= slice[CHUNK];
                    if (idx == LAST) begin
                        cout_r <= slice[CHUNK];
                        ovf_r  <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                                  (slice[CHUNK-1] != opa[WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule
